// File: rtl/neuron_pkg.sv
// Shared neuron definitions: FSM state encoding and the default weights/threshold
// so the synapse and neuron stages agree on them.
package neuron_pkg;

    typedef enum logic {
        INTEGRATE  = 1'b0,
        REFRACTORY = 1'b1
    } neuron_state_e;

    localparam int unsigned DEF_WIDTH          = 8;
    localparam int unsigned DEF_THRESHOLD      = 16;
    localparam int unsigned DEF_WEIGHT_EXC     = 4;
    localparam int unsigned DEF_WEIGHT_INH     = 3;
    localparam int unsigned DEF_LEAK_PERIOD    = 4;
    localparam int unsigned DEF_REFRACT_CYCLES = 3;

endpackage

// File: rtl/neuron_leak_timer.sv
// Free-running leak counter 0..LEAK_PERIOD-1; leak_tick_o marks the last count.
// LEAK_PERIOD=0 disables the tick and holds the counter at zero.
module neuron_leak_timer
    import neuron_pkg::*;
#(
    parameter int unsigned LEAK_PERIOD = DEF_LEAK_PERIOD
) (
    input  logic clk,
    input  logic reset_i,
    output logic leak_tick_o
);

    localparam int unsigned CW   = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
    localparam int unsigned LAST = (LEAK_PERIOD == 0) ? 0 : LEAK_PERIOD - 1;

    logic [CW-1:0] r_cnt;
    logic          w_tick;

    assign w_tick      = (LEAK_PERIOD != 0) && (r_cnt == CW'(LAST));
    assign leak_tick_o = w_tick;

    always_ff @(posedge clk) begin
        if (reset_i || w_tick || (LEAK_PERIOD == 0)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/lif_neuron_core.sv
// Leaky integrate-and-fire neuron: integrates excitatory/inhibitory pulses with a
// periodic leak, fires a one-cycle spike at threshold, then goes refractory.
module lif_neuron_core
    import neuron_pkg::*;
#(
    parameter int unsigned WIDTH          = DEF_WIDTH,
    parameter int unsigned THRESHOLD      = DEF_THRESHOLD,
    parameter int unsigned WEIGHT_EXC     = DEF_WEIGHT_EXC,
    parameter int unsigned WEIGHT_INH     = DEF_WEIGHT_INH,
    parameter int unsigned LEAK_PERIOD    = DEF_LEAK_PERIOD,
    parameter int unsigned REFRACT_CYCLES = DEF_REFRACT_CYCLES
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             excite_i,
    input  logic             inhibit_i,
    output logic             spike_o,
    output logic [WIDTH-1:0] potential_o,
    output logic             refractory_o
);

    localparam int unsigned SW = WIDTH + 2;
    localparam int unsigned RW = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;
    localparam logic [WIDTH-1:0] POT_MAX = '1;

    neuron_state_e    r_state;
    logic [WIDTH-1:0] r_pot;
    logic             r_spike;
    logic [RW-1:0]    r_rcnt;

    logic             w_leak_tick;
    logic [SW-1:0]    w_sum;
    logic [WIDTH-1:0] w_clamp;
    logic             w_fire;

    neuron_leak_timer #(
        .LEAK_PERIOD (LEAK_PERIOD)
    ) u_leak_timer (
        .clk         (clk),
        .reset_i     (reset_i),
        .leak_tick_o (w_leak_tick)
    );

    // Two's-complement net sum in WIDTH+2 bits: top bit flags underflow, bit WIDTH overflow.
    assign w_sum = {2'b00, r_pot}
                 + (excite_i    ? SW'(WEIGHT_EXC) : SW'(0))
                 - (inhibit_i   ? SW'(WEIGHT_INH) : SW'(0))
                 - (w_leak_tick ? SW'(1)          : SW'(0));

    always_comb begin
        w_clamp = w_sum[WIDTH-1:0];
        if (w_sum[SW-1]) begin
            w_clamp = '0;
        end else if (w_sum[WIDTH]) begin
            w_clamp = POT_MAX;
        end
    end

    assign w_fire = (w_clamp >= WIDTH'(THRESHOLD));

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_state <= INTEGRATE;
            r_pot   <= '0;
            r_spike <= 1'b0;
            r_rcnt  <= '0;
        end else begin
            case (r_state)
                INTEGRATE: begin
                    if (w_fire) begin
                        r_spike <= 1'b1;
                        r_pot   <= '0;
                        if (REFRACT_CYCLES != 0) begin
                            r_state <= REFRACTORY;
                            r_rcnt  <= RW'(REFRACT_CYCLES);
                        end
                    end else begin
                        r_spike <= 1'b0;
                        r_pot   <= w_clamp;
                    end
                end
                REFRACTORY: begin
                    // Inputs and leak ticks are dropped, not queued.
                    r_spike <= 1'b0;
                    r_pot   <= '0;
                    if (r_rcnt == RW'(1)) begin
                        r_state <= INTEGRATE;
                        r_rcnt  <= '0;
                    end else begin
                        r_rcnt <= r_rcnt - RW'(1);
                    end
                end
                default: r_state <= INTEGRATE;
            endcase
        end
    end

    assign spike_o      = r_spike;
    assign potential_o  = r_pot;
    assign refractory_o = (r_state == REFRACTORY);

endmodule

// File: tb/tb_lif_neuron_core.sv
// Bench for lif_neuron_core: a no-leak and a leak-period-4 instance share inputs and
// are compared each cycle with a cycle-count based neuron model, plus directed checks.
module tb_lif_neuron_core;

    logic       clk = 1'b0;
    logic       reset_i = 1'b0;
    logic       excite_i = 1'b0;
    logic       inhibit_i = 1'b0;
    logic       spike0, spike4, refr0, refr4;
    logic [7:0] pot0, pot4;

    int n_checks = 0;
    int n_errors = 0;

    // model state per instance: index 0 -> no leak, index 1 -> leak every 4 cycles
    int m_pot[2];
    int m_spk[2];
    int m_rleft[2];
    int m_cyc[2];
    int m_period[2] = '{0, 4};

    always #5 clk = ~clk;

    lif_neuron_core #(.LEAK_PERIOD(0)) dut0 (
        .clk(clk), .reset_i(reset_i), .excite_i(excite_i), .inhibit_i(inhibit_i),
        .spike_o(spike0), .potential_o(pot0), .refractory_o(refr0)
    );

    lif_neuron_core #(.LEAK_PERIOD(4)) dut4 (
        .clk(clk), .reset_i(reset_i), .excite_i(excite_i), .inhibit_i(inhibit_i),
        .spike_o(spike4), .potential_o(pot4), .refractory_o(refr4)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Model of one clock edge, derived from the neuron's rules with plain integers.
    task automatic model_edge(input int k, input bit r, input bit e, input bit inh);
        int s;
        bit tick;
        if (r) begin
            m_pot[k] = 0; m_spk[k] = 0; m_rleft[k] = 0; m_cyc[k] = 0;
        end else begin
            tick = (m_period[k] != 0) && ((m_cyc[k] % m_period[k]) == m_period[k] - 1);
            m_cyc[k]++;
            if (m_rleft[k] > 0) begin
                m_rleft[k]--;
                m_spk[k] = 0;
                m_pot[k] = 0;
            end else begin
                s = m_pot[k] + (e ? 4 : 0) - (inh ? 3 : 0) - (tick ? 1 : 0);
                if (s < 0) s = 0;
                if (s > 255) s = 255;
                if (s >= 16) begin
                    m_spk[k] = 1; m_pot[k] = 0; m_rleft[k] = 3;
                end else begin
                    m_spk[k] = 0; m_pot[k] = s;
                end
            end
        end
    endtask

    // Drive one cycle, advance the model, compare both instances on the falling edge.
    task automatic cyc(input bit r, input bit e, input bit inh);
        reset_i = r; excite_i = e; inhibit_i = inh;
        @(posedge clk);
        model_edge(0, r, e, inh);
        model_edge(1, r, e, inh);
        @(negedge clk);
        chk("pot_p0",   int'(pot0),   m_pot[0]);
        chk("spike_p0", int'(spike0), m_spk[0]);
        chk("refr_p0",  int'(refr0),  int'(m_rleft[0] > 0));
        chk("pot_p4",   int'(pot4),   m_pot[1]);
        chk("spike_p4", int'(spike4), m_spk[1]);
        chk("refr_p4",  int'(refr4),  int'(m_rleft[1] > 0));
    endtask

    initial begin
        // 1: reset dominates excite
        cyc(1, 1, 0);
        chk("rst_pot", int'(pot0), 0);
        cyc(1, 1, 0);
        chk("rst_spike", int'(spike0), 0);
        chk("rst_refr", int'(refr0), 0);

        // 2: integrate to fire without leak
        cyc(0, 1, 0); chk("int_4", int'(pot0), 4);
        cyc(0, 1, 0); chk("int_8", int'(pot0), 8);
        cyc(0, 1, 0); chk("int_12", int'(pot0), 12);
        cyc(0, 1, 0); chk("fire_spike", int'(spike0), 1);
        chk("fire_pot", int'(pot0), 0);
        chk("fire_refr", int'(refr0), 1);

        // 3: refractory drops excitation for exactly 3 cycles
        cyc(0, 1, 0); chk("refr_spike_low", int'(spike0), 0);
        chk("refr_hold", int'(pot0), 0);
        cyc(0, 1, 0); chk("refr_still", int'(refr0), 1);
        cyc(0, 1, 0); chk("refr_fell", int'(refr0), 0);
        chk("refr_lost", int'(pot0), 0);
        cyc(0, 1, 0); chk("post_refr_4", int'(pot0), 4);

        // 4: net sum and clamp at zero
        cyc(1, 0, 0);
        cyc(0, 1, 1); chk("net_1", int'(pot0), 1);
        cyc(0, 0, 1); chk("clamp_0", int'(pot0), 0);
        cyc(0, 0, 1); chk("clamp_hold", int'(pot0), 0);

        // 5: leak decays 8 toward 0 and stays there
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        cyc(0, 1, 0); chk("leak_start", int'(pot4), 8);
        repeat (40) cyc(0, 0, 0);
        chk("leak_floor", int'(pot4), 0);

        // 6: reset in the middle of refractory
        cyc(1, 0, 0);
        repeat (4) cyc(0, 1, 0);
        chk("mid_fire", int'(spike0), 1);
        cyc(0, 0, 0);
        cyc(1, 0, 0); chk("mid_rst_refr", int'(refr0), 0);
        cyc(0, 1, 0); chk("mid_rst_pot", int'(pot0), 4);

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lif_neuron_core.md
Name: lif_neuron_core

Overview:
Leaky integrate-and-fire neuron that consumes the one-cycle excitatory/inhibitory pulses produced by the synapse edge-detection stage.
- Rising-edge pulses add weight to a membrane potential; falling-edge pulses subtract weight.
- A periodic leak decays the potential toward zero.
- Crossing threshold emits a one-cycle spike, followed by a refractory period.
- Sits downstream of the LFSR/edge-detector synapse path; the spike output feeds output pins or a downstream neuron's input.

Parameters:
- WIDTH, 8, membrane potential width in bits (unsigned).
- THRESHOLD, 16, fire when the updated potential is >= THRESHOLD; must be in 1..2^WIDTH-1.
- WEIGHT_EXC, 4, amount added per excitatory pulse.
- WEIGHT_INH, 3, amount subtracted per inhibitory pulse.
- LEAK_PERIOD, 4, cycles between leak ticks; 0 disables leak.
- REFRACT_CYCLES, 3, cycles inputs are ignored after a spike; 0 means no refractory period.

Ports:
- clk  input  1  single system clock, rising edge.
- reset_i  input  1  synchronous, active-high reset.
- excite_i  input  1  excitatory pulse, one cycle per event (rising-edge pulse).
- inhibit_i  input  1  inhibitory pulse, one cycle per event (falling-edge pulse).
- spike_o  output  1  registered one-cycle fire pulse.
- potential_o  output  WIDTH  registered membrane potential.
- refractory_o  output  1  high while in REFRACTORY.

Behaviour:
- Reset (reset_i high at clk edge) has priority over everything, including mid-refractory. All of the following clear to 0: potential_o, spike_o, refractory_o, leak counter, refractory counter. State goes to INTEGRATE.
- States: INTEGRATE, REFRACTORY.
- Leak counter: free-running 0..LEAK_PERIOD-1, counts in both states. leak_tick = (counter == LEAK_PERIOD-1); it then wraps to 0. With LEAK_PERIOD=0, leak_tick is always 0 and the counter is held at 0.
- INTEGRATE, each cycle:
  - sum = potential + (excite_i ? WEIGHT_EXC : 0) - (inhibit_i ? WEIGHT_INH : 0) - (leak_tick ? 1 : 0).
  - Compute sum signed in WIDTH+2 bits, then clamp to [0, 2^WIDTH-1]. No wrap-around ever.
  - Simultaneous excite, inhibit and leak all apply in the same cycle as a net sum.
  - If clamped sum >= THRESHOLD: at this edge, spike_o<=1 and potential<=0.
    - If REFRACT_CYCLES>0: state<=REFRACTORY, refractory counter<=REFRACT_CYCLES.
    - If REFRACT_CYCLES=0: stay in INTEGRATE.
  - Otherwise potential<=clamped sum and spike_o<=0.
- Latency: the input pulse on cycle N produces spike_o high on cycle N+1, i.e. visible after edge N.
- spike_o is high for exactly one cycle per fire. Back-to-back spikes are only possible when REFRACT_CYCLES=0.
- REFRACTORY:
  - excite_i, inhibit_i and leak ticks are ignored; potential held at 0; spike_o=0; refractory_o=1.
  - Counter decrements each cycle. When it equals 1 at an edge, state<=INTEGRATE and refractory_o<=0.
  - Refractory therefore lasts exactly REFRACT_CYCLES cycles. Pulses arriving on those cycles are lost, not queued.
- Leak at potential 0 with no excitation: clamps to 0 with no underflow.
- Saturation: potential sticks at 2^WIDTH-1 only if THRESHOLD is unreachable, which the legal THRESHOLD range prevents. The clamp is still required.

Decomposition:
- Shared package neuron_pkg:
  - state encoding (INTEGRATE=1'b0, REFRACTORY=1'b1);
  - default WIDTH/THRESHOLD/weight constants, so the synapse and neuron stages agree on weights.
- One natural sub-module: neuron_leak_timer (LEAK_PERIOD counter producing leak_tick, with the LEAK_PERIOD=0 disable). Everything else stays in lif_neuron_core.

Test Plan:
1. Reset: drive reset_i=1 for 2 cycles with excite_i=1 -> potential_o=0, spike_o=0, refractory_o=0 throughout.
2. Integrate to fire (LEAK_PERIOD=0, defaults otherwise): excite_i=1 for 4 consecutive cycles -> potential_o 4, 8, 12. After the 4th edge: spike_o=1 for one cycle, potential_o=0, refractory_o=1 for exactly 3 cycles.
3. Refractory discard: after case 2, keep excite_i=1 during refractory -> potential_o stays 0. The first increment to 4 appears on the edge after refractory_o falls.
4. Simultaneous/net and clamp (LEAK_PERIOD=0): excite_i=inhibit_i=1 from 0 -> potential_o=1. Then inhibit only -> potential_o=0, not 254.
5. Leak (LEAK_PERIOD=4): excite to potential 8, then idle -> potential_o decrements by 1 every 4th cycle down to 0 and stays 0.
6. Reset mid-refractory: assert reset_i on the 2nd refractory cycle -> next cycle refractory_o=0, state INTEGRATE. A following excite gives potential_o=4.
